// File: rtl/bloom_row_query_pkg.sv
// Shared row-layout constants, log2 helper and FSM encoding for the bloom row query path.
package bloom_row_query_pkg;

    function automatic int log2c(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    localparam int DATA_WIDTH     = 72;
    localparam int NUM_BUCKETS    = 14;
    localparam int BUCKET_SZ      = 4;
    localparam int BITS_SHIFT     = log2c(NUM_BUCKETS);
    localparam int BLOOM_INIT_POS = 16;
    localparam int ADDR_WIDTH     = 10;
    localparam int LOOP_W         = BLOOM_INIT_POS - BITS_SHIFT;
    localparam int BLOOM_W        = DATA_WIDTH - BLOOM_INIT_POS;
    localparam int BIT_W          = log2c(BUCKET_SZ);
    localparam int SH_W           = BITS_SHIFT + 1;
    localparam int CNT_W          = BITS_SHIFT + 1;
    localparam int SHAMT_W        = log2c(BLOOM_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_AGE     = 3'd3,
`ifdef ROW_REFRESH_EN
        S_WRBK    = 3'd4,
`endif
        S_RESP    = 3'd5
    } state_e;

    function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_BUCKETS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int k = 0; k < NUM_BUCKETS; k++) c = c + CNT_W'(v[k]);
        return c;
    endfunction

endpackage

// File: rtl/bloom_row_query_ager.sv
// Virtual aging of a stored row to a given (loop,bucket) time base: shift computation and barrel shift.
module bloom_row_ager
    import bloom_row_query_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] row_i,
    input  logic [BITS_SHIFT-1:0] cur_bucket_i,
    input  logic [LOOP_W-1:0]     cur_loop_i,
    output logic [BLOOM_W-1:0]    aged_o,
    output logic                  future_o
);

    logic [LOOP_W-1:0]     row_loop;
    logic [BITS_SHIFT-1:0] row_bucket;
    logic [BLOOM_W-1:0]    bloom;
    logic [LOOP_W-1:0]     d;
    logic [SH_W-1:0]       shift;
    logic [SHAMT_W-1:0]    amt;

    assign row_loop   = row_i[LOOP_W-1:0];
    assign row_bucket = row_i[BLOOM_INIT_POS-1 -: BITS_SHIFT];
    assign bloom      = row_i[DATA_WIDTH-1:BLOOM_INIT_POS];

    // Loop distance is modular, so the 2^LOOP_W-1 -> 0 wrap is simply d==1.
    always_comb begin
        d        = cur_loop_i - row_loop;
        shift    = '0;
        future_o = 1'b0;
        if (d == '0) begin
            if (cur_bucket_i >= row_bucket) shift = {1'b0, cur_bucket_i - row_bucket};
            else                            future_o = 1'b1;
        end else if (d == LOOP_W'(1)) begin
            shift = SH_W'(NUM_BUCKETS) - {1'b0, row_bucket} + {1'b0, cur_bucket_i};
        end else if (d[LOOP_W-1]) begin
            future_o = 1'b1;
        end else begin
            shift = SH_W'(NUM_BUCKETS);
        end
    end

    always_comb begin
        amt    = SHAMT_W'(shift) * SHAMT_W'(BUCKET_SZ);
        aged_o = (shift >= SH_W'(NUM_BUCKETS)) ? '0 : (bloom >> amt);
    end

endmodule

// File: rtl/bloom_row_query.sv
// Bloom row membership query: fetch row, age it to the latched time base, report per-bucket hits.
// Optional ROW_REFRESH_EN writes the aged row back to row memory before responding.
module bloom_row_query
    import bloom_row_query_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   q_vld,
    output logic                   q_rdy,
    input  logic [ADDR_WIDTH-1:0]  q_addr,
    input  logic [BIT_W-1:0]       q_bit,
    input  logic [BITS_SHIFT-1:0]  cur_bucket,
    input  logic [LOOP_W-1:0]      cur_loop,
    output logic                   mem_rd_req,
    output logic [ADDR_WIDTH-1:0]  mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]  mem_rd_data,
    input  logic                   mem_rd_vld,
`ifdef ROW_REFRESH_EN
    output logic                   mem_wr_req,
    output logic [ADDR_WIDTH-1:0]  mem_wr_addr,
    output logic [DATA_WIDTH-1:0]  mem_wr_data,
`endif
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic                   out_hit,
    output logic [NUM_BUCKETS-1:0] out_hit_vec,
    output logic [CNT_W-1:0]       out_hit_cnt,
    output logic                   err_future
);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [BIT_W-1:0]       bit_q;
    logic [BITS_SHIFT-1:0]  cb_q;
    logic [LOOP_W-1:0]      cl_q;
    logic [DATA_WIDTH-1:0]  row_q;
    logic [NUM_BUCKETS-1:0] hv_q, hv_d;
    logic [CNT_W-1:0]       cnt_q;
    logic                   hit_q;
    logic                   errf_q;
    logic [BLOOM_W-1:0]     aged;
    logic                   future;

    bloom_row_ager u_ager (
        .row_i        (row_q),
        .cur_bucket_i (cb_q),
        .cur_loop_i   (cl_q),
        .aged_o       (aged),
        .future_o     (future)
    );

    always_comb begin
        hv_d = '0;
        for (int k = 0; k < NUM_BUCKETS; k++)
            hv_d[k] = aged[k*BUCKET_SZ + int'(bit_q)];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (q_vld) state_d = S_RD_REQ;
            S_RD_REQ:  state_d = S_RD_WAIT;
            S_RD_WAIT: if (mem_rd_vld) state_d = S_AGE;
`ifdef ROW_REFRESH_EN
            S_AGE:     state_d = S_WRBK;
            S_WRBK:    state_d = S_RESP;
`else
            S_AGE:     state_d = S_RESP;
`endif
            S_RESP:    if (out_rdy) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

`ifdef ROW_REFRESH_EN
    logic [DATA_WIDTH-1:0] wr_data_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            bit_q   <= '0;
            cb_q    <= '0;
            cl_q    <= '0;
            row_q   <= '0;
            hv_q    <= '0;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            errf_q  <= 1'b0;
`ifdef ROW_REFRESH_EN
            wr_data_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && q_vld) begin
                addr_q <= q_addr;
                bit_q  <= q_bit;
                cb_q   <= cur_bucket;
                cl_q   <= cur_loop;
            end
            if (state_q == S_RD_WAIT && mem_rd_vld) row_q <= mem_rd_data;
            if (state_q == S_AGE) begin
                hv_q  <= hv_d;
                cnt_q <= popcnt(hv_d);
                hit_q <= |hv_d;
                if (future) errf_q <= 1'b1;
`ifdef ROW_REFRESH_EN
                // A future row keeps its own header; its bloom is unshifted anyway.
                wr_data_q <= future ? row_q : {aged, cb_q, cl_q};
`endif
            end
        end
    end

    assign q_rdy       = (state_q == S_IDLE);
    assign mem_rd_req  = (state_q == S_RD_REQ);
    assign mem_rd_addr = addr_q;
    assign out_vld     = (state_q == S_RESP);
    assign out_hit     = hit_q;
    assign out_hit_vec = hv_q;
    assign out_hit_cnt = cnt_q;
    assign err_future  = errf_q;

`ifdef ROW_REFRESH_EN
    assign mem_wr_req  = (state_q == S_WRBK);
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = wr_data_q;
`endif

endmodule
